// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the IF/ID front end of the 5-stage MIPS pipeline.
//   - Default reset PC and NOP word (sll $0,$0,0).
//   - Instruction field bounds for rs / rt.
//   - PC increment constant and a PC word-alignment helper.
//   - Per-edge action enum that orders the IF/ID update priority.
package if_id_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Update applied to PC and IF/ID on the next rising edge, highest priority first.
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_BRANCH,
    ACT_JUMP,
    ACT_SEQ
  } pc_action_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// hazard_detect: purely combinational load-use hazard detector.
// Ports:
//   ValidID   in  1  IF/ID holds a real instruction
//   MemReadEX in  1  instruction in EX is a load
//   RtEX      in  5  load destination register
//   RsID      in  5  rs field of the instruction in ID
//   RtID      in  5  rt field of the instruction in ID
//   Hazard    out 1  ID must stall one cycle
// Detection is conservative: rt is compared even for formats that do not read it.
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic             ValidID,
  input  logic             MemReadEX,
  input  logic [REG_W-1:0] RtEX,
  input  logic [REG_W-1:0] RsID,
  input  logic [REG_W-1:0] RtID,
  output logic             Hazard
);

  always_comb begin
    Hazard = 1'b0;
    if (ValidID && MemReadEX && (RtEX != '0)) begin
      Hazard = (RtEX == RsID) || (RtEX == RtID);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, PC+4 adder and IF/ID pipeline register, with
// load-use stall and ID-resolved branch/jump redirect.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   InstructionIF     word fetched from instruction memory at PCIF
//   BranchTakenID / BranchTargetID   taken branch in ID and its target
//   JumpID / JumpTargetID            j/jal in ID and its target
//   MemReadEX / RtEX  load in EX and its destination register
//   PCIF              current PC (instruction memory address)
//   InstructionID, PC4ID, ValidID    IF/ID register contents
//   StallID, FlushIDEX               combinational load-use stall / ID/EX bubble
//   StallCount, SquashCount          performance counters
// Optional feature: define IF_ID_PERF_COUNT_EN to build the counters;
// otherwise both counter ports read 32'h0.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] InstructionIF,
  input  logic        BranchTakenID,
  input  logic [31:0] BranchTargetID,
  input  logic        JumpID,
  input  logic [31:0] JumpTargetID,
  input  logic        MemReadEX,
  input  logic [4:0]  RtEX,
  output logic [31:0] PCIF,
  output logic [31:0] InstructionID,
  output logic [31:0] PC4ID,
  output logic        ValidID,
  output logic        StallID,
  output logic        FlushIDEX,
  output logic [31:0] StallCount,
  output logic [31:0] SquashCount
);

  logic       hazard;
  logic [31:0] pcPlus4;
  pc_action_e action;

  hazard_detect uHazardDetect (
    .ValidID   (ValidID),
    .MemReadEX (MemReadEX),
    .RtEX      (RtEX),
    .RsID      (InstructionID[RS_MSB:RS_LSB]),
    .RtID      (InstructionID[RT_MSB:RT_LSB]),
    .Hazard    (hazard)
  );

  assign StallID   = hazard;
  assign FlushIDEX = hazard;
  assign pcPlus4   = PCIF + PC_INCR;

  // A stall outranks a redirect: ID re-asserts the redirect once operands are ready.
  always_comb begin
    action = ACT_SEQ;
    if (reset) begin
      action = ACT_RESET;
    end else if (hazard) begin
      action = ACT_HOLD;
    end else if (BranchTakenID) begin
      action = ACT_BRANCH;
    end else if (JumpID) begin
      action = ACT_JUMP;
    end
  end

  always_ff @(posedge clock) begin
    case (action)
      ACT_RESET: begin
        PCIF          <= RESET_PC;
        InstructionID <= NOP_WORD;
        PC4ID         <= '0;
        ValidID       <= 1'b0;
      end
      ACT_HOLD: begin
      end
      ACT_BRANCH: begin
        PCIF          <= alignPc(BranchTargetID);
        InstructionID <= NOP_WORD;
        PC4ID         <= '0;
        ValidID       <= 1'b0;
      end
      ACT_JUMP: begin
        PCIF          <= alignPc(JumpTargetID);
        InstructionID <= NOP_WORD;
        PC4ID         <= '0;
        ValidID       <= 1'b0;
      end
      default: begin
        PCIF          <= pcPlus4;
        InstructionID <= InstructionIF;
        PC4ID         <= pcPlus4;
        ValidID       <= 1'b1;
      end
    endcase
  end

`ifdef IF_ID_PERF_COUNT_EN
  logic [31:0] stallCountQ;
  logic [31:0] squashCountQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      stallCountQ  <= '0;
      squashCountQ <= '0;
    end else begin
      if (action == ACT_HOLD) begin
        stallCountQ <= stallCountQ + 32'd1;
      end
      if ((action == ACT_BRANCH) || (action == ACT_JUMP)) begin
        squashCountQ <= squashCountQ + 32'd1;
      end
    end
  end

  assign StallCount  = stallCountQ;
  assign SquashCount = squashCountQ;
`else
  assign StallCount  = '0;
  assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

`ifdef IF_ID_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] InstructionIF;
  logic        BranchTakenID = 1'b0;
  logic [31:0] BranchTargetID = '0;
  logic        JumpID = 1'b0;
  logic [31:0] JumpTargetID = '0;
  logic        MemReadEX = 1'b0;
  logic [4:0]  RtEX = '0;
  logic [31:0] PCIF, InstructionID, PC4ID, StallCount, SquashCount;
  logic        ValidID, StallID, FlushIDEX;

  logic [31:0] imem [0:255];

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit          started = 1'b0;
  logic [31:0] mPC, mIns, mPC4, mStalls, mSquashes;
  logic        mValid;

  if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .InstructionIF(InstructionIF),
    .BranchTakenID(BranchTakenID), .BranchTargetID(BranchTargetID),
    .JumpID(JumpID), .JumpTargetID(JumpTargetID),
    .MemReadEX(MemReadEX), .RtEX(RtEX),
    .PCIF(PCIF), .InstructionID(InstructionID), .PC4ID(PC4ID), .ValidID(ValidID),
    .StallID(StallID), .FlushIDEX(FlushIDEX),
    .StallCount(StallCount), .SquashCount(SquashCount)
  );

  always #5 clock = ~clock;

  assign InstructionIF = imem[PCIF[9:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelHazard();
    logic [4:0] rs, rt;
    rs = mIns[25:21];
    rt = mIns[20:16];
    return mValid && MemReadEX && (RtEX != 5'd0) && (RtEX == rs || RtEX == rt);
  endfunction

  // Reference model: applies the per-edge priority rules directly.
  always @(posedge clock) begin
    if (reset) begin
      started   = 1'b1;
      mPC       = 32'h0;
      mIns      = 32'h0;
      mPC4      = 32'h0;
      mValid    = 1'b0;
      mStalls   = 32'h0;
      mSquashes = 32'h0;
    end else if (started) begin
      if (modelHazard()) begin
        mStalls = mStalls + 1;
      end else if (BranchTakenID || JumpID) begin
        mPC       = (BranchTakenID ? BranchTargetID : JumpTargetID) & 32'hFFFF_FFFC;
        mIns      = 32'h0;
        mPC4      = 32'h0;
        mValid    = 1'b0;
        mSquashes = mSquashes + 1;
      end else begin
        mIns   = imem[mPC[9:2]];
        mPC    = mPC + 32'd4;
        mPC4   = mPC;
        mValid = 1'b1;
      end
    end
  end

  // Compare process
  always @(negedge clock) begin
    if (started) begin
      check("PCIF", PCIF, mPC);
      check("InstructionID", InstructionID, mIns);
      check("PC4ID", PC4ID, mPC4);
      check("ValidID", {31'b0, ValidID}, {31'b0, mValid});
      check("StallID", {31'b0, StallID}, {31'b0, modelHazard()});
      check("FlushIDEX", {31'b0, FlushIDEX}, {31'b0, modelHazard()});
      check("StallCount", StallCount, PERF ? mStalls : 32'h0);
      check("SquashCount", SquashCount, PERF ? mSquashes : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0]   = 32'h2008_0005;
    imem[1]   = 32'h2009_0003;
    imem[2]   = 32'h0109_5020;  // add $10,$8,$9
    imem[3]   = 32'h2000_0007;  // rs=0, rt=0
    imem[16]  = 32'h8D2A_0000;  // lw $10,0($9)
    imem[255] = 32'h8D2A_0000;

    tick();
    reset = 1'b0;
    check("rst_PCIF", PCIF, 32'h0);
    check("rst_InstructionID", InstructionID, 32'h0);
    check("rst_PC4ID", PC4ID, 32'h0);
    check("rst_ValidID", {31'b0, ValidID}, 32'h0);
    check("rst_StallID", {31'b0, StallID}, 32'h0);

    tick();
    check("run1_PCIF", PCIF, 32'h4);
    check("run1_InstructionID", InstructionID, 32'h2008_0005);
    check("run1_PC4ID", PC4ID, 32'h4);
    check("run1_ValidID", {31'b0, ValidID}, 32'h1);
    tick();
    check("run2_PCIF", PCIF, 32'h8);
    tick();
    check("run3_PCIF", PCIF, 32'hC);
    check("run3_StallID", {31'b0, StallID}, 32'h0);

    // Load-use against add $10,$8,$9
    MemReadEX = 1'b1; RtEX = 5'd8;
    #1;
    check("lu_StallID", {31'b0, StallID}, 32'h1);
    check("lu_FlushIDEX", {31'b0, FlushIDEX}, 32'h1);
    tick();
    check("lu_PCIF_hold", PCIF, 32'hC);
    check("lu_InstructionID_hold", InstructionID, 32'h0109_5020);
    check("lu_StallCount", StallCount, PERF ? 32'h1 : 32'h0);
    MemReadEX = 1'b0;
    #1;
    check("lu_clear", {31'b0, StallID}, 32'h0);

    tick();
    check("rs0_InstructionID", InstructionID, 32'h2000_0007);
    MemReadEX = 1'b1; RtEX = 5'd0;
    #1;
    check("rt0_no_stall", {31'b0, StallID}, 32'h0);

    // Branch at PCIF=0x10 to unaligned target
    BranchTakenID = 1'b1; BranchTargetID = 32'h0000_0043;
    tick();
    check("br_PCIF", PCIF, 32'h40);
    check("br_InstructionID", InstructionID, 32'h0);
    check("br_ValidID", {31'b0, ValidID}, 32'h0);
    check("br_SquashCount", SquashCount, PERF ? 32'h1 : 32'h0);
    BranchTakenID = 1'b0; MemReadEX = 1'b0;

    tick();
    check("j_pre_PCIF", PCIF, 32'h44);
    MemReadEX = 1'b1; RtEX = 5'd10; JumpID = 1'b1; JumpTargetID = 32'h100;
    #1;
    check("hz_jump_StallID", {31'b0, StallID}, 32'h1);
    tick();
    check("hz_jump_hold", PCIF, 32'h44);
    MemReadEX = 1'b0;
    tick();
    check("jump_PCIF", PCIF, 32'h100);

    JumpTargetID = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre", PCIF, 32'hFFFF_FFFC);
    JumpID = 1'b0;
    tick();
    check("wrap_PCIF", PCIF, 32'h0);
    check("wrap_PC4ID", PC4ID, 32'h0);

    // Reset during a stall
    MemReadEX = 1'b1; RtEX = 5'd9;
    #1;
    check("rs_stall", {31'b0, StallID}, 32'h1);
    reset = 1'b1;
    tick();
    check("rs_PCIF", PCIF, 32'h0);
    check("rs_InstructionID", InstructionID, 32'h0);
    check("rs_ValidID", {31'b0, ValidID}, 32'h0);
    check("rs_StallID", {31'b0, StallID}, 32'h0);
    check("rs_StallCount", StallCount, 32'h0);
    check("rs_SquashCount", SquashCount, 32'h0);
    reset = 1'b0; MemReadEX = 1'b0;

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset         = ($urandom_range(0, 99) == 0);
      BranchTakenID = ($urandom_range(0, 7) == 0);
      JumpID        = ($urandom_range(0, 7) == 0);
      BranchTargetID = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
      JumpTargetID   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : $urandom;
      MemReadEX     = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: RtEX = mIns[25:21];
        1: RtEX = mIns[20:16];
        2: RtEX = 5'd0;
        default: RtEX = 5'($urandom);
      endcase
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
